decomp_sequencer: RTL and testbench

//  Sequences instruction decompression between imem and the decode stage.

---
 rtl/decomp_sequencer.sv | 120 ++++++++++++
 tb/tb_decomp_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/decomp_sequencer.sv
// Instruction decompression sequencer between imem and decode: passes normal words
// through one register stage and expands 4'hF tokens into 1..16 token-table entries.
module decomp_sequencer #(
    parameter int WIDTH = 32,
    parameter int TT_AW = 6,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] instr_in,
    input  logic             instr_valid,
    input  logic             out_ready,
    input  logic             flush,
    output logic [TT_AW-1:0] tt_addr,
    input  logic [WIDTH-1:0] tt_data,
    output logic [WIDTH-1:0] out_instr,
    output logic             out_valid,
    output logic             fetch_stall,
    output logic             busy,
    output logic [CNT_W-1:0] tok_count
);

    typedef enum logic {S_PASS, S_EXPAND} state_t;

    state_t           r_state, w_state_nxt;
    logic [TT_AW-1:0] r_base, w_base_nxt;
    logic [3:0]       r_idx, w_idx_nxt;
    logic [3:0]       r_cnt, w_cnt_nxt;
    logic [WIDTH-1:0] r_out_instr, w_out_instr_nxt;
    logic             r_out_valid, w_out_valid_nxt;
    logic [CNT_W-1:0] r_tok_count, w_tok_count_nxt;

    logic w_can_load;
    logic w_accept;
    logic w_is_token;

    assign w_can_load  = out_ready | ~r_out_valid;
    assign w_accept    = (r_state == S_PASS) & instr_valid & w_can_load & ~flush;
    assign w_is_token  = (instr_in[WIDTH-1 -: 4] == 4'hF);

    assign fetch_stall = instr_valid & ~w_accept & ~flush;
    // Table address wraps modulo the table depth.
    assign tt_addr     = r_base + TT_AW'(r_idx);
    assign out_instr   = r_out_instr;
    assign out_valid   = r_out_valid;
    assign busy        = (r_state == S_EXPAND);
    assign tok_count   = r_tok_count;

    always_comb begin
        w_state_nxt     = r_state;
        w_base_nxt      = r_base;
        w_idx_nxt       = r_idx;
        w_cnt_nxt       = r_cnt;
        w_out_instr_nxt = r_out_instr;
        w_out_valid_nxt = r_out_valid;
        w_tok_count_nxt = r_tok_count;

        // Flush overrides everything; the word on instr_in is dropped, even a token.
        if (flush) begin
            w_state_nxt     = S_PASS;
            w_idx_nxt       = 4'd0;
            w_out_valid_nxt = 1'b0;
        end else begin
            case (r_state)
                S_PASS: begin
                    if (w_accept) begin
                        if (w_is_token) begin
                            w_state_nxt     = S_EXPAND;
                            w_base_nxt      = instr_in[TT_AW-1:0];
                            w_cnt_nxt       = instr_in[WIDTH-5 -: 4];
                            w_idx_nxt       = 4'd0;
                            w_out_instr_nxt = '0;
                            w_out_valid_nxt = 1'b0;
                            if (r_tok_count != {CNT_W{1'b1}})
                                w_tok_count_nxt = r_tok_count + CNT_W'(1);
                        end else begin
                            w_out_instr_nxt = instr_in;
                            w_out_valid_nxt = 1'b1;
                        end
                    end else if (w_can_load) begin
                        w_out_valid_nxt = 1'b0;
                    end
                end
                S_EXPAND: begin
                    if (w_can_load) begin
                        w_out_instr_nxt = tt_data;
                        w_out_valid_nxt = 1'b1;
                        w_idx_nxt       = r_idx + 4'd1;
                        if (r_idx == r_cnt) begin
                            w_state_nxt = S_PASS;
                            w_idx_nxt   = 4'd0;
                        end
                    end
                end
                default: w_state_nxt = S_PASS;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_PASS;
            r_base      <= '0;
            r_idx       <= 4'd0;
            r_cnt       <= 4'd0;
            r_out_instr <= '0;
            r_out_valid <= 1'b0;
            r_tok_count <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_base      <= w_base_nxt;
            r_idx       <= w_idx_nxt;
            r_cnt       <= w_cnt_nxt;
            r_out_instr <= w_out_instr_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_tok_count <= w_tok_count_nxt;
        end
    end

endmodule

// File: tb/tb_decomp_sequencer.sv
// Directed bench for decomp_sequencer; token table entry i holds 32'hA000_0000 | i.
module tb_decomp_sequencer;

    logic        clk;
    logic        reset;
    logic [31:0] instr_in;
    logic        instr_valid;
    logic        out_ready;
    logic        flush;
    logic [5:0]  tt_addr;
    logic [31:0] tt_data;
    logic [31:0] out_instr;
    logic        out_valid;
    logic        fetch_stall;
    logic        busy;
    logic [15:0] tok_count;

    logic [31:0] tt_mem [64];
    int          n_checks;
    int          n_fail;

    decomp_sequencer #(.WIDTH(32), .TT_AW(6), .CNT_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .instr_in    (instr_in),
        .instr_valid (instr_valid),
        .out_ready   (out_ready),
        .flush       (flush),
        .tt_addr     (tt_addr),
        .tt_data     (tt_data),
        .out_instr   (out_instr),
        .out_valid   (out_valid),
        .fetch_stall (fetch_stall),
        .busy        (busy),
        .tok_count   (tok_count)
    );

    assign tt_data = tt_mem[tt_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 64; i++) tt_mem[i] = 32'hA000_0000 | i;
        reset = 1'b0; instr_in = '0; instr_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        #12;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_tok_count", {16'd0, tok_count}, 32'd0);
        chk("rst_tt_addr", {26'd0, tt_addr}, 32'd0);
        chk("rst_fetch_stall", {31'd0, fetch_stall}, 32'd0);
        tick();
        reset = 1'b1; out_ready = 1'b1;

        // T1 pass-through
        instr_in = 32'hE081_0002; instr_valid = 1'b1; #1;
        chk("t1_stall0", {31'd0, fetch_stall}, 32'd0);
        tick();
        chk("t1_out0", out_instr, 32'hE081_0002);
        chk("t1_vld0", {31'd0, out_valid}, 32'd1);
        instr_in = 32'hE242_2001; #1;
        chk("t1_stall1", {31'd0, fetch_stall}, 32'd0);
        tick();
        chk("t1_out1", out_instr, 32'hE242_2001);
        instr_in = 32'hE150_0003; #1;
        chk("t1_stall2", {31'd0, fetch_stall}, 32'd0);
        tick();
        chk("t1_out2", out_instr, 32'hE150_0003);
        instr_valid = 1'b0;
        tick();
        chk("t1_idle_vld", {31'd0, out_valid}, 32'd0);

        // T2 expand with T3 backpressure after A1
        instr_in = 32'hF300_0010; instr_valid = 1'b1; #1;
        chk("t2_tok_stall", {31'd0, fetch_stall}, 32'd0);
        tick();
        chk("t2_busy", {31'd0, busy}, 32'd1);
        chk("t2_bubble", {31'd0, out_valid}, 32'd0);
        instr_in = 32'hE081_0002; #1;
        chk("t2_stall_a", {31'd0, fetch_stall}, 32'd1);
        chk("t2_addr0", {26'd0, tt_addr}, 32'h10);
        tick();
        chk("t2_a0", out_instr, 32'hA000_0010);
        chk("t2_a0_vld", {31'd0, out_valid}, 32'd1);
        chk("t2_addr1", {26'd0, tt_addr}, 32'h11);
        chk("t2_stall_b", {31'd0, fetch_stall}, 32'd1);
        tick();
        chk("t2_a1", out_instr, 32'hA000_0011);
        out_ready = 1'b0; #1;
        chk("t3_stall", {31'd0, fetch_stall}, 32'd1);
        tick();
        chk("t3_hold_a1_0", out_instr, 32'hA000_0011);
        chk("t3_addr_0", {26'd0, tt_addr}, 32'h12);
        tick();
        chk("t3_hold_a1_1", out_instr, 32'hA000_0011);
        chk("t3_addr_1", {26'd0, tt_addr}, 32'h12);
        chk("t3_busy", {31'd0, busy}, 32'd1);
        out_ready = 1'b1;
        tick();
        chk("t2_a2", out_instr, 32'hA000_0012);
        chk("t2_addr3", {26'd0, tt_addr}, 32'h13);
        tick();
        chk("t2_a3", out_instr, 32'hA000_0013);
        chk("t2_done_busy", {31'd0, busy}, 32'd0);
        chk("t2_release", {31'd0, fetch_stall}, 32'd0);
        tick();
        chk("t2_next", out_instr, 32'hE081_0002);
        chk("t2_tok_count", {16'd0, tok_count}, 32'd1);
        instr_valid = 1'b0;
        tick();
        chk("t2_idle_vld", {31'd0, out_valid}, 32'd0);

        // T4 table address wrap
        instr_in = 32'hF300_003E; instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0; #1;
        chk("t4_addr0", {26'd0, tt_addr}, 32'h3E);
        tick();
        chk("t4_d0", out_instr, 32'hA000_003E);
        chk("t4_addr1", {26'd0, tt_addr}, 32'h3F);
        tick();
        chk("t4_d1", out_instr, 32'hA000_003F);
        chk("t4_addr2", {26'd0, tt_addr}, 32'h00);
        tick();
        chk("t4_d2", out_instr, 32'hA000_0000);
        chk("t4_addr3", {26'd0, tt_addr}, 32'h01);
        tick();
        chk("t4_d3", out_instr, 32'hA000_0001);
        chk("t4_busy", {31'd0, busy}, 32'd0);
        chk("t4_tok_count", {16'd0, tok_count}, 32'd2);
        tick();
        chk("t4_idle_vld", {31'd0, out_valid}, 32'd0);

        // T5 flush mid-expansion
        instr_in = 32'hF300_0010; instr_valid = 1'b1;
        tick();
        instr_in = 32'hE242_2001;
        tick();
        tick();
        chk("t5_a1", out_instr, 32'hA000_0011);
        flush = 1'b1; #1;
        chk("t5_flush_stall", {31'd0, fetch_stall}, 32'd0);
        tick();
        chk("t5_vld", {31'd0, out_valid}, 32'd0);
        chk("t5_busy", {31'd0, busy}, 32'd0);
        chk("t5_tok_count", {16'd0, tok_count}, 32'd3);
        chk("t5_addr", {26'd0, tt_addr}, 32'h10);
        flush = 1'b0; #1;
        chk("t5_accept", {31'd0, fetch_stall}, 32'd0);
        tick();
        chk("t5_next", out_instr, 32'hE242_2001);
        chk("t5_next_vld", {31'd0, out_valid}, 32'd1);
        instr_valid = 1'b0;
        tick();
        chk("t5_no_a2", {31'd0, out_valid}, 32'd0);

        // Flush coincident with a token: token dropped, not counted
        instr_in = 32'hF300_0020; instr_valid = 1'b1; flush = 1'b1;
        tick();
        chk("fx_busy", {31'd0, busy}, 32'd0);
        chk("fx_tok_count", {16'd0, tok_count}, 32'd3);
        chk("fx_vld", {31'd0, out_valid}, 32'd0);
        flush = 1'b0; instr_valid = 1'b0;

        // T6 async reset mid-expansion
        instr_in = 32'hF300_0010; instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick();
        chk("t6_pre_vld", {31'd0, out_valid}, 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("t6_vld", {31'd0, out_valid}, 32'd0);
        chk("t6_busy", {31'd0, busy}, 32'd0);
        chk("t6_tok_count", {16'd0, tok_count}, 32'd0);
        chk("t6_out", out_instr, 32'd0);
        tick();
        reset = 1'b1;
        instr_in = 32'hE150_0003; instr_valid = 1'b1; #1;
        chk("t6_stall", {31'd0, fetch_stall}, 32'd0);
        tick();
        chk("t6_pass", out_instr, 32'hE150_0003);
        chk("t6_pass_vld", {31'd0, out_valid}, 32'd1);
        instr_valid = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
